// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the decode/issue register file and its pending scoreboard.
// Also holds the parameter sanity helper used at elaboration.
package regfile_scoreboard_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int REG_ZERO      = 0;

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_arbiter.sv
// Combinational write-port arbiter: per register, a one-hot winning port select and a strobe.
// A higher port index wins a collision; register 0 never receives a strobe.
module regfile_write_arbiter
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NWRITE = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*AW-1:0]    wr_addr,
  output logic [NREGS*NWRITE-1:0] wr_sel,
  output logic [NREGS-1:0]        wr_strobe
);

  // Scanning ports in ascending order lets a later match overwrite an earlier one.
  always_comb begin
    wr_sel    = '0;
    wr_strobe = '0;
    for (int r = REG_ZERO + 1; r < NREGS; r++) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          wr_sel[r*NWRITE +: NWRITE] = '0;
          wr_sel[r*NWRITE + j]       = 1'b1;
          wr_strobe[r]               = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported integer register file with prioritised writes, optional write-to-read bypass
// and a per-register pending scoreboard for destinations claimed at issue.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_pending,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   claim_en,
  input  logic [AW-1:0]          claim_addr,
  input  logic                   flush,
  output logic                   any_pending
);

  if (NREAD < 1) begin : g_bad_nread
    $error("regfile_scoreboard: NREAD must be at least 1");
  end
  if (NWRITE < 1) begin : g_bad_nwrite
    $error("regfile_scoreboard: NWRITE must be at least 1");
  end
  if (!is_pow2(NREGS)) begin : g_bad_nregs
    $error("regfile_scoreboard: NREGS must be a power of two >= 2");
  end

  logic [XLEN-1:0]         regs     [NREGS];
  logic [XLEN-1:0]         win_data [NREGS];
  logic [NREGS-1:0]        pending;
  logic [NREGS-1:0]        claim_hit;
  logic [NREGS-1:0]        wr_strobe;
  logic [NREGS*NWRITE-1:0] wr_sel;

  regfile_write_arbiter #(
    .NREGS  (NREGS),
    .NWRITE (NWRITE),
    .AW     (AW)
  ) u_arbiter (
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_sel    (wr_sel),
    .wr_strobe (wr_strobe)
  );

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      win_data[r] = '0;
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_sel[r*NWRITE + j]) begin
          win_data[r] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Claims to the zero register are dropped here so it can never turn pending.
  always_comb begin
    claim_hit = '0;
    if (claim_en && (claim_addr != AW'(REG_ZERO))) begin
      claim_hit[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = REG_ZERO + 1; r < NREGS; r++) begin
        if (wr_strobe[r]) begin
          regs[r] <= win_data[r];
        end
      end
    end
  end

  // A new claim supersedes a retiring write to the same register; flush beats both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (claim_hit[r]) begin
          pending[r] <= 1'b1;
        end else if (wr_strobe[r]) begin
          pending[r] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0] addr;
    logic          bypass_hit;

    assign addr       = rd_addr[i*AW +: AW];
    assign bypass_hit = BYPASS && wr_strobe[addr];

    assign rd_data[i*XLEN +: XLEN] = bypass_hit ? win_data[addr] : regs[addr];
    assign rd_pending[i]           = pending[addr] && !(bypass_hit && !claim_hit[addr]);
  end

  assign any_pending = |pending;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing and a non-bypassing instance share all stimulus
// and are compared against an architectural model of registers and pending bits.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_en;
  logic [4:0]  ra [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        flush;

  logic [9:0]  rd_addr_f;
  logic [9:0]  wr_addr_f;
  logic [63:0] wr_data_f;
  logic [63:0] rd_data_b, rd_data_s;
  logic [1:0]  rd_pend_b, rd_pend_s;
  logic        any_b, any_s;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  int tests    = 0;
  int failures = 0;

  assign rd_addr_f = {ra[1], ra[0]};
  assign wr_addr_f = {wa[1], wa[0]};
  assign wr_data_f = {wd[1], wd[0]};

  always #5 clk = ~clk;

  regfile_scoreboard #(.BYPASS(1'b1)) dut_byp (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr_f),
    .rd_data     (rd_data_b),
    .rd_pending  (rd_pend_b),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr_f),
    .wr_data     (wr_data_f),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .flush       (flush),
    .any_pending (any_b)
  );

  regfile_scoreboard #(.BYPASS(1'b0)) dut_std (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr_f),
    .rd_data     (rd_data_s),
    .rd_pending  (rd_pend_s),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr_f),
    .wr_data     (wr_data_f),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .flush       (flush),
    .any_pending (any_s)
  );

  // Highest-numbered enabled port aimed at r, or -1 if nobody writes r this cycle.
  function automatic int winner(input int r);
    if (r == 0) return -1;
    for (int j = 1; j >= 0; j--) begin
      if (wr_en[j] && (int'(wa[j]) == r)) return j;
    end
    return -1;
  endfunction

  function automatic bit any_model_pending();
    for (int r = 0; r < 32; r++) begin
      if (m_pend[r]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    int          a;
    int          w;
    logic [31:0] exp_data;
    logic        exp_pend;
    for (int i = 0; i < 2; i++) begin
      a        = int'(ra[i]);
      w        = winner(a);
      exp_data = (w >= 0) ? wd[w] : m_regs[a];
      exp_pend = m_pend[a] && !((w >= 0) && !(claim_en && (int'(claim_addr) == a) && (a != 0)));
      check_val($sformatf("rd_data_byp[%0d] x%0d", i, a), rd_data_b[i*32 +: 32], exp_data);
      check_val($sformatf("rd_data_std[%0d] x%0d", i, a), rd_data_s[i*32 +: 32], m_regs[a]);
      check_val($sformatf("rd_pend_byp[%0d] x%0d", i, a), 32'(rd_pend_b[i]), 32'(exp_pend));
      check_val($sformatf("rd_pend_std[%0d] x%0d", i, a), 32'(rd_pend_s[i]), 32'(m_pend[a]));
    end
    check_val("any_pending_byp", 32'(any_b), 32'(any_model_pending()));
    check_val("any_pending_std", 32'(any_s), 32'(any_model_pending()));
  endtask

  task automatic apply_stimulus(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic ce, input logic [4:0] ca, input logic fl);
    wr_en      = we;
    wa[0]      = wa0;
    wa[1]      = wa1;
    wd[0]      = wd0;
    wd[1]      = wd1;
    ra[0]      = ra0;
    ra[1]      = ra1;
    claim_en   = ce;
    claim_addr = ca;
    flush      = fl;
    #1;
    check_output();
  endtask

  task automatic apply_idle(input logic [4:0] ra0, input logic [4:0] ra1);
    apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, ra0, ra1, 1'b0, 5'd0, 1'b0);
  endtask

  // Architectural update at a rising edge, from the inputs held across it.
  task automatic clock_edge();
    logic [31:0] nr [32];
    bit          np [32];
    int          w;
    nr = m_regs;
    np = m_pend;
    for (int r = 1; r < 32; r++) begin
      w = winner(r);
      if (w >= 0) nr[r] = wd[w];
      if (flush) np[r] = 1'b0;
      else if (claim_en && (int'(claim_addr) == r)) np[r] = 1'b1;
      else if (w >= 0) np[r] = 1'b0;
    end
    @(posedge clk);
    m_regs = nr;
    m_pend = np;
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    reset = 1'b0;
    apply_idle(5'd5, 5'd0);
    #10;
    check_val("reset rd_data_byp[0] x5", rd_data_b[31:0], 32'h0);
    check_val("reset rd_pending_byp", 32'(rd_pend_b), 32'h0);
    check_val("reset any_pending", 32'(any_b), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    apply_idle(5'd31, 5'd0);
    check_val("post-reset x31", rd_data_b[31:0], 32'h0);

    // Same-address collision: port 1 must win.
    apply_stimulus(2'b11, 5'd7, 5'd7, 32'hAAAA0000, 32'hBBBB0000, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    check_val("collision bypass x7", rd_data_b[31:0], 32'hBBBB0000);
    check_val("collision stored x7", rd_data_s[31:0], 32'h0);
    clock_edge();
    apply_idle(5'd7, 5'd7);
    check_val("collision committed byp x7", rd_data_b[31:0], 32'hBBBB0000);
    check_val("collision committed std x7", rd_data_s[63:32], 32'hBBBB0000);

    apply_stimulus(2'b01, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    check_val("x0 bypass read", rd_data_b[31:0], 32'h0);
    clock_edge();
    apply_idle(5'd0, 5'd0);
    check_val("x0 read", rd_data_b[31:0], 32'h0);
    check_val("x0 any_pending", 32'(any_b), 32'h0);

    // Scoreboard lifecycle on x3.
    apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0);
    clock_edge();
    apply_idle(5'd3, 5'd0);
    check_val("x3 pending after claim", 32'(rd_pend_b[0]), 32'h1);
    check_val("any_pending after claim", 32'(any_b), 32'h1);
    apply_stimulus(2'b01, 5'd3, 5'd0, 32'h12, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    check_val("x3 pending bypassed", 32'(rd_pend_b[0]), 32'h0);
    check_val("x3 pending stored", 32'(rd_pend_s[0]), 32'h1);
    clock_edge();
    apply_idle(5'd3, 5'd0);
    check_val("x3 data after write", rd_data_s[31:0], 32'h12);
    check_val("x3 pending after write", 32'(rd_pend_s[0]), 32'h0);

    // Claim and write race on x4.
    apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0);
    clock_edge();
    apply_stimulus(2'b10, 5'd0, 5'd4, 32'h0, 32'h55, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0);
    check_val("race pending byp", 32'(rd_pend_b[0]), 32'h1);
    clock_edge();
    apply_idle(5'd4, 5'd0);
    check_val("race x4 data", rd_data_s[31:0], 32'h55);
    check_val("race x4 pending", 32'(rd_pend_s[0]), 32'h1);

    // Flush with a concurrent claim and write.
    apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b1, 5'd1, 1'b0);
    clock_edge();
    apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b1, 5'd2, 1'b0);
    clock_edge();
    apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd2, 1'b1, 5'd9, 1'b0);
    clock_edge();
    apply_stimulus(2'b01, 5'd2, 5'd0, 32'h77, 32'h0, 5'd2, 5'd10, 1'b1, 5'd10, 1'b1);
    clock_edge();
    apply_idle(5'd2, 5'd10);
    check_val("flush any_pending", 32'(any_s), 32'h0);
    check_val("flush x2 data", rd_data_s[31:0], 32'h77);
    check_val("flush x10 pending", 32'(rd_pend_s[1]), 32'h0);

    for (int n = 0; n < 400; n++) begin
      apply_stimulus(2'($urandom), rand_addr(), rand_addr(), $urandom, $urandom,
                     rand_addr(), rand_addr(), ($urandom_range(0, 2) == 0),
                     rand_addr(), ($urandom_range(0, 15) == 0));
      clock_edge();
    end

    // Asynchronous reset between edges clears everything at once.
    apply_stimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, rand_addr(), rand_addr(), 1'b1, 5'd6, 1'b0);
    clock_edge();
    #2;
    reset = 1'b0;
    model_reset();
    apply_idle(5'd6, 5'd7);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 40; n++) begin
      apply_stimulus(2'($urandom), rand_addr(), rand_addr(), $urandom, $urandom,
                     rand_addr(), rand_addr(), ($urandom_range(0, 2) == 0),
                     rand_addr(), ($urandom_range(0, 15) == 0));
      clock_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file with NREAD combinational read ports, NWRITE prioritised write ports, optional write-to-read bypass and a per-register pending scoreboard. Successor to the current 2-read/1+1-write register file. Sits in decode/issue: decode reads operands and claims destinations; writeback and atomic/memory units retire results through the write ports. Register 0 is hardwired to zero and can never become pending.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >= 2)
NREAD, 2, number of read ports
NWRITE, 2, number of write ports; a higher index has higher priority
BYPASS, 1, 1 = a read returns the same-cycle winning write data; 0 = a read returns the stored value
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_addr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_pending  out  NREAD  1 = the addressed register awaits an outstanding write
wr_en  in  NWRITE  write enables
wr_addr  in  NWRITE*AW  write addresses
wr_data  in  NWRITE*XLEN  write data
claim_en  in  1  mark claim_addr pending (destination reserved at issue)
claim_addr  in  AW  register to reserve
flush  in  1  clear every pending bit (pipeline flush)
any_pending  out  1  OR of all pending bits

Behaviour:
- Reset (reset=0, asynchronous): every register = 0, every pending bit = 0. The outputs are combinational from this state, so rd_data = 0, rd_pending = 0 and any_pending = 0 while reset is held.
- Address 0: reads return 0 and rd_pending = 0. Writes and claims to address 0 are ignored.
- Write resolution per register r: winner = the highest-index port j with wr_en[j] && wr_addr[j]==r && r!=0. The register takes wr_data[j] at the next rising clk. Losing ports to the same address are discarded. Writes to different addresses all commit in the same cycle.
- Read (combinational, 0-cycle latency): with BYPASS=1, if any write port targets rd_addr[i] in this cycle, rd_data[i] = the winning wr_data; otherwise the stored value. With BYPASS=0, rd_data[i] always returns the stored value, and the new value appears the cycle after the write.
- Scoreboard, per register r, evaluated at the clock edge in this priority order:
  1. flush = 1: all pending bits are cleared. A claim in the same cycle is ignored.
  2. claim_en && claim_addr==r: pending[r] = 1. A claim wins over a same-cycle write to r, because the new producer supersedes the retiring one.
  3. A winning write to r: pending[r] = 0.
  4. Otherwise pending[r] is held.
- rd_pending[i] reflects the stored pending bit. With BYPASS=1, rd_pending[i] is also forced to 0 when a same-cycle write targets rd_addr[i], unless a same-cycle claim targets the same address.
- Writes commit normally during flush. Flush affects only the scoreboard.
- Reset asserted mid-cycle overrides everything immediately. The first clock edge after deassertion behaves as normal operation.
- Elaboration error if NREAD < 1, NWRITE < 1, or NREGS is not a power of two.

Decomposition:
- Shared package/header (cpu/defines.vh): XLEN default, NREGS default, and register-index constant REG_ZERO.
- One natural sub-module: regfile_write_arbiter, which is combinational. It takes NWRITE enables and addresses and produces, per register, a one-hot winner select and a write strobe. The top level uses it for both storage update and the bypass mux.

Test Plan:
- Reset: hold reset=0, drive rd_addr = {5,0} -> rd_data = 0, rd_pending = 0, any_pending = 0. Release reset, read x31 -> 0.
- Collision: wr_en=2'b11, wr_addr={7,7}, wr_data={32'hBBBB0000, 32'hAAAA0000} -> next cycle x7 = 32'hBBBB0000. Same cycle with BYPASS=1, rd_addr=7 -> rd_data = 32'hBBBB0000. With BYPASS=0, the same read shows the old value.
- x0 protection: write 32'hDEADBEEF to x0 and claim x0 -> reads 0, rd_pending = 0, any_pending = 0.
- Scoreboard lifecycle: claim x3 -> rd_pending(x3)=1 and any_pending=1 next cycle. Write x3 = 32'h12 -> pending clears next cycle, and rd_pending=0 in the write cycle when BYPASS=1.
- Claim/write race: with x4 pending, claim x4 and write x4=32'h55 in the same cycle -> x4 = 32'h55, pending stays 1.
- Flush: claim x1, x2, x9 over three cycles, then assert flush together with claim x10 and a write to x2 = 32'h77 -> all pending = 0, x2 = 32'h77, x10 not pending.
